tea_stream_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares one TEA encryptor/decryptor AXI-Stream

---
 rtl/tea_stream_arbiter.sv | 140 ++++++++++++++
 tb/tb_tea_stream_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tea_stream_arbiter
//
// Packet-granular round-robin arbiter sharing one TEA core AXI-Stream slave
// between NUM_SRC AXI-Stream masters. A grant is held from the first beat up
// to and including the TLAST beat, so packets are never interleaved. The
// output carries the granted source index on M_TID so a downstream splitter
// can route results back.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   S_TVALID/S_TREADY     per-source handshake (one bit per source)
//   S_TDATA/TSTRB/TKEEP   per-source payload, source i at slice i
//   S_TLAST/S_TDEST       per-source end-of-packet and destination
//   M_TVALID/M_TREADY     handshake towards the TEA core
//   M_TDATA..M_TDEST      registered payload of the accepted beat
//   M_TID                 zero-extended index of the source that sent the beat
//   GRANT                 one-hot current grant (status, zero when idle)
// -----------------------------------------------------------------------------
module tea_stream_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int WIDTH_DATA  = 64,
  parameter int WIDTH_DS    = 8,
  parameter int WIDTH_TID   = 8,
  parameter int WIDTH_TDEST = 3
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [NUM_SRC-1:0]             S_TVALID,
  output logic [NUM_SRC-1:0]             S_TREADY,
  input  logic [NUM_SRC*WIDTH_DATA-1:0]  S_TDATA,
  input  logic [NUM_SRC*WIDTH_DS-1:0]    S_TSTRB,
  input  logic [NUM_SRC*WIDTH_DS-1:0]    S_TKEEP,
  input  logic [NUM_SRC-1:0]             S_TLAST,
  input  logic [NUM_SRC*WIDTH_TDEST-1:0] S_TDEST,
  output logic                           M_TVALID,
  input  logic                           M_TREADY,
  output logic [WIDTH_DATA-1:0]          M_TDATA,
  output logic [WIDTH_DS-1:0]            M_TSTRB,
  output logic [WIDTH_DS-1:0]            M_TKEEP,
  output logic                           M_TLAST,
  output logic [WIDTH_TID-1:0]           M_TID,
  output logic [WIDTH_TDEST-1:0]         M_TDEST,
  output logic [NUM_SRC-1:0]             GRANT
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_last;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             out_free;
  logic             accept;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = ~M_TVALID | M_TREADY;
  assign accept   = (state == ST_XFER) && S_TVALID[grant_idx] && out_free;

  // Round-robin pick: scan rr_last+1, rr_last+2, ... and take the first valid.
  // NOTE: every variable driven here gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_idx = rr_last;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(rr_last) + k) % NUM_SRC);
      if (!found && S_TVALID[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  // Ready depends only on state and the output register, never on S_TVALID.
  always_comb begin
    S_TREADY = '0;
    if (state == ST_XFER) S_TREADY[grant_idx] = out_free;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_last   <= IDX_W'(NUM_SRC - 1);
      GRANT     <= '0;
      M_TVALID  <= 1'b0;
      M_TDATA   <= '0;
      M_TSTRB   <= '0;
      M_TKEEP   <= '0;
      M_TLAST   <= 1'b0;
      M_TID     <= '0;
      M_TDEST   <= '0;
    end else begin
      // Output register: load on an accepted beat, otherwise drain.
      if (accept) begin
        M_TVALID <= 1'b1;
        M_TDATA  <= S_TDATA[int'(grant_idx)*WIDTH_DATA +: WIDTH_DATA];
        M_TSTRB  <= S_TSTRB[int'(grant_idx)*WIDTH_DS +: WIDTH_DS];
        M_TKEEP  <= S_TKEEP[int'(grant_idx)*WIDTH_DS +: WIDTH_DS];
        M_TLAST  <= S_TLAST[grant_idx];
        M_TID    <= WIDTH_TID'(grant_idx);
        M_TDEST  <= S_TDEST[int'(grant_idx)*WIDTH_TDEST +: WIDTH_TDEST];
      end else if (M_TREADY) begin
        M_TVALID <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_idx <= next_idx;
            GRANT     <= NUM_SRC'(1) << next_idx;
            state     <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Grant is released on the TLAST beat; the output register still
          // holds that beat until the core takes it.
          if (accept && S_TLAST[grant_idx]) begin
            rr_last <= grant_idx;
            GRANT   <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_stream_arbiter.sv
module tb_tea_stream_arbiter;

  localparam int NS  = 2;
  localparam int WD  = 64;
  localparam int WDS = 8;
  localparam int WT  = 8;
  localparam int WDE = 3;

  typedef struct {
    logic [WD-1:0]  data;
    logic [WDS-1:0] keep;
    logic [WDS-1:0] strb;
    logic           last;
    logic [WDE-1:0] dest;
    int             gap;   // idle source cycles before this beat is offered
  } beat_t;

  typedef struct {
    logic [WD-1:0]  data;
    logic [WDS-1:0] keep;
    logic [WDS-1:0] strb;
    logic           last;
    logic [WT-1:0]  tid;
    logic [WDE-1:0] dest;
    int             cyc;
  } obs_t;

  logic                ACLK;
  logic                ARESET;
  logic [NS-1:0]       S_TVALID;
  logic [NS-1:0]       S_TREADY;
  logic [NS*WD-1:0]    S_TDATA;
  logic [NS*WDS-1:0]   S_TSTRB;
  logic [NS*WDS-1:0]   S_TKEEP;
  logic [NS-1:0]       S_TLAST;
  logic [NS*WDE-1:0]   S_TDEST;
  logic                M_TVALID;
  logic                M_TREADY;
  logic [WD-1:0]       M_TDATA;
  logic [WDS-1:0]      M_TSTRB;
  logic [WDS-1:0]      M_TKEEP;
  logic                M_TLAST;
  logic [WT-1:0]       M_TID;
  logic [WDE-1:0]      M_TDEST;
  logic [NS-1:0]       GRANT;

  tea_stream_arbiter #(
    .NUM_SRC(NS), .WIDTH_DATA(WD), .WIDTH_DS(WDS), .WIDTH_TID(WT), .WIDTH_TDEST(WDE)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
    .S_TSTRB(S_TSTRB), .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST), .S_TDEST(S_TDEST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
    .M_TSTRB(M_TSTRB), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST),
    .M_TID(M_TID), .M_TDEST(M_TDEST), .GRANT(GRANT)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Source-side stimulus state
  beat_t    srcq [NS][$];
  int       gap_left [NS];
  int       first_valid_cyc [NS];
  bit [NS-1:0] pop;
  bit       force_valid;
  bit       tready_toggle;
  int       cyc;
  beat_t    hb;
  bit       hv;

  // Reference model: packets still to be scheduled and the expected stream
  beat_t    mq [NS][$];
  obs_t     expq[$];
  obs_t     obsq[$];
  int       model_last;

  // Source drivers and sink ready: update just after each rising edge.
  always @(posedge ACLK) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < NS; i++) begin
      if (pop[i] && !ARESET && srcq[i].size() > 0) begin
        srcq[i].delete(0);
        if (srcq[i].size() > 0) gap_left[i] = srcq[i][0].gap;
      end
      pop[i] = 1'b0;
      hv = 1'b0;
      if (srcq[i].size() > 0) begin
        if (gap_left[i] > 0) gap_left[i] = gap_left[i] - 1;
        else begin
          hv = 1'b1;
          hb = srcq[i][0];
        end
      end
      if (hv && !S_TVALID[i]) first_valid_cyc[i] = cyc;
      S_TVALID[i]            = hv | force_valid;
      S_TDATA[i*WD +: WD]    = hv ? hb.data : {$urandom, $urandom};
      S_TKEEP[i*WDS +: WDS]  = hv ? hb.keep : WDS'($urandom);
      S_TSTRB[i*WDS +: WDS]  = hv ? hb.strb : WDS'($urandom);
      S_TDEST[i*WDE +: WDE]  = hv ? hb.dest : WDE'($urandom);
      S_TLAST[i]             = hv ? hb.last : 1'($urandom);
    end
    M_TREADY = tready_toggle ? ~M_TREADY : 1'b1;
  end

  // Monitor: mid-cycle, record source handshakes and output transfers.
  obs_t mo;
  always @(negedge ACLK) begin
    for (int i = 0; i < NS; i++) pop[i] = S_TVALID[i] & S_TREADY[i];
    if (M_TVALID === 1'b1 && M_TREADY === 1'b1) begin
      mo.data = M_TDATA; mo.keep = M_TKEEP; mo.strb = M_TSTRB; mo.last = M_TLAST;
      mo.tid  = M_TID;   mo.dest = M_TDEST; mo.cyc  = cyc;
      obsq.push_back(mo);
    end
  end

  task automatic queue_packet(input int src, input int nbeats, input bit seq,
                              input int gap_beat, input int gap);
    beat_t b;
    for (int j = 0; j < nbeats; j++) begin
      b.data = seq ? WD'(j + 1) : {$urandom, $urandom};
      b.keep = WDS'($urandom);
      b.strb = WDS'($urandom);
      b.dest = WDE'($urandom);
      b.last = (j == nbeats - 1);
      b.gap  = (j == gap_beat) ? gap : 0;
      srcq[src].push_back(b);
      mq[src].push_back(b);
    end
  endtask

  // Whole packets, one at a time, sources visited in rotation after the last
  // winner; every queued packet is assumed offered at arbitration time.
  function automatic void model_schedule();
    int    s;
    beat_t b;
    obs_t  e;
    while (1) begin
      s = -1;
      for (int k = 1; k <= NS; k++)
        if (s < 0 && mq[(model_last + k) % NS].size() > 0) s = (model_last + k) % NS;
      if (s < 0) break;
      do begin
        b = mq[s].pop_front();
        e.data = b.data; e.keep = b.keep; e.strb = b.strb; e.last = b.last;
        e.dest = b.dest; e.tid = WT'(s); e.cyc = 0;
        expq.push_back(e);
      end while (!b.last);
      model_last = s;
    end
  endfunction

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obsq.size() < n && k < budget) begin
      @(negedge ACLK); #1;
      k++;
    end
    ok = (obsq.size() >= n);
  endtask

  task automatic start_scenario();
    obsq.delete();
    expq.delete();
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    force_valid = 1'b1;
    model_last = NS - 1;
    repeat (3) begin
      @(negedge ACLK); #1;
      n_checks++;
      if (M_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset M_TVALID: got %b want 0", M_TVALID); end
      n_checks++;
      if (S_TREADY !== '0) begin n_fail++; $display("FAIL reset S_TREADY: got %b want 0", S_TREADY); end
      n_checks++;
      if (GRANT !== '0) begin n_fail++; $display("FAIL reset GRANT: got %b want 0", GRANT); end
    end
    n_checks++;
    if (M_TDATA !== '0 || M_TID !== '0 || M_TLAST !== 1'b0)
      begin n_fail++; $display("FAIL reset M_data: got data=%h tid=%0d last=%b want zeros", M_TDATA, M_TID, M_TLAST); end
    force_valid = 1'b0;
    @(negedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  task automatic test_single_source();
    bit ok;
    start_scenario();
    queue_packet(1, 4, 1'b1, -1, 0);
    model_schedule();
    wait_obs(4, 100, ok);
    repeat (4) @(negedge ACLK);
    #1;
    n_checks++;
    if (!ok || obsq.size() != expq.size())
      begin n_fail++; $display("FAIL single count: got %0d beats want %0d", obsq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      n_checks++;
      if (obsq[i] .data !== expq[i].data || obsq[i].tid !== expq[i].tid || obsq[i].last !== expq[i].last ||
          obsq[i].keep !== expq[i].keep || obsq[i].strb !== expq[i].strb || obsq[i].dest !== expq[i].dest) begin
        n_fail++;
        $display("FAIL single beat%0d: got data=%h tid=%0d last=%b want data=%h tid=%0d last=%b",
                 i, obsq[i].data, obsq[i].tid, obsq[i].last, expq[i].data, expq[i].tid, expq[i].last);
      end
      if (i > 0) begin
        n_checks++;
        if (obsq[i].cyc - obsq[i-1].cyc != 1)
          begin n_fail++; $display("FAIL single spacing beat%0d: got %0d cycles want 1", i, obsq[i].cyc - obsq[i-1].cyc); end
      end
    end
    if (obsq.size() > 0) begin
      n_checks++;
      if (obsq[0].cyc - first_valid_cyc[1] != 2)
        begin n_fail++; $display("FAIL single latency: got %0d cycles want 2", obsq[0].cyc - first_valid_cyc[1]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int want;
    start_scenario();
    for (int p = 0; p < 2; p++) begin
      queue_packet(0, 3, 1'b0, -1, 0);
      queue_packet(1, 3, 1'b0, -1, 0);
    end
    model_schedule();
    wait_obs(expq.size(), 200, ok);
    repeat (4) @(negedge ACLK);
    #1;
    n_checks++;
    if (!ok || obsq.size() != expq.size())
      begin n_fail++; $display("FAIL b2b count: got %0d beats want %0d", obsq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      n_checks++;
      if (obsq[i].data !== expq[i].data || obsq[i].tid !== expq[i].tid || obsq[i].last !== expq[i].last ||
          obsq[i].keep !== expq[i].keep || obsq[i].strb !== expq[i].strb || obsq[i].dest !== expq[i].dest) begin
        n_fail++;
        $display("FAIL b2b beat%0d: got data=%h tid=%0d last=%b want data=%h tid=%0d last=%b",
                 i, obsq[i].data, obsq[i].tid, obsq[i].last, expq[i].data, expq[i].tid, expq[i].last);
      end
      if (i > 0) begin
        want = expq[i-1].last ? 2 : 1;
        n_checks++;
        if (obsq[i].cyc - obsq[i-1].cyc != want)
          begin n_fail++; $display("FAIL b2b spacing beat%0d: got %0d cycles want %0d", i, obsq[i].cyc - obsq[i-1].cyc, want); end
      end
    end
  endtask

  task automatic test_valid_drop();
    bit ok;
    int k = 0;
    int drops = 0;
    start_scenario();
    queue_packet(0, 4, 1'b0, 2, 5);
    queue_packet(1, 2, 1'b0, -1, 0);
    model_schedule();
    while (obsq.size() < expq.size() && k < 300) begin
      @(negedge ACLK); #1;
      k++;
      if (srcq[0].size() > 0 && !S_TVALID[0]) begin
        drops++;
        n_checks++;
        if (GRANT !== 2'b01) begin n_fail++; $display("FAIL drop GRANT: got %b want 01", GRANT); end
      end
    end
    ok = (obsq.size() >= expq.size());
    n_checks++;
    if (drops != 5) begin n_fail++; $display("FAIL drop cycles: got %0d want 5", drops); end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL drop count: got %0d beats want %0d", obsq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      n_checks++;
      if (obsq[i].data !== expq[i].data || obsq[i].tid !== expq[i].tid || obsq[i].last !== expq[i].last) begin
        n_fail++;
        $display("FAIL drop beat%0d: got data=%h tid=%0d last=%b want data=%h tid=%0d last=%b",
                 i, obsq[i].data, obsq[i].tid, obsq[i].last, expq[i].data, expq[i].tid, expq[i].last);
      end
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    obs_t prev;
    bit   prev_stall = 1'b0;
    int   stalls = 0;
    int   k = 0;
    start_scenario();
    tready_toggle = 1'b1;
    queue_packet(0, 4, 1'b0, -1, 0);
    model_schedule();
    while (obsq.size() < expq.size() && k < 200) begin
      @(negedge ACLK); #1;
      k++;
      if (prev_stall) begin
        stalls++;
        n_checks++;
        if (M_TVALID !== 1'b1 || M_TDATA !== prev.data || M_TLAST !== prev.last ||
            M_TID !== prev.tid || M_TKEEP !== prev.keep || M_TDEST !== prev.dest) begin
          n_fail++;
          $display("FAIL stall hold: got valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                   M_TVALID, M_TDATA, M_TLAST, prev.data, prev.last);
        end
      end
      prev_stall = (M_TVALID === 1'b1) && (M_TREADY === 1'b0);
      prev.data = M_TDATA; prev.last = M_TLAST; prev.tid = M_TID;
      prev.keep = M_TKEEP; prev.dest = M_TDEST;
    end
    tready_toggle = 1'b0;
    repeat (4) @(negedge ACLK);
    #1;
    ok = (obsq.size() == expq.size());
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp count: got %0d beats want %0d", obsq.size(), expq.size()); end
    n_checks++;
    if (stalls == 0) begin n_fail++; $display("FAIL bp stalls: got 0 stalled cycles want >0"); end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      n_checks++;
      if (obsq[i].data !== expq[i].data || obsq[i].tid !== expq[i].tid || obsq[i].last !== expq[i].last) begin
        n_fail++;
        $display("FAIL bp beat%0d: got data=%h tid=%0d last=%b want data=%h tid=%0d last=%b",
                 i, obsq[i].data, obsq[i].tid, obsq[i].last, expq[i].data, expq[i].tid, expq[i].last);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    bit found = 1'b0;
    int k = 0;
    start_scenario();
    queue_packet(1, 4, 1'b0, -1, 0);
    while (!found && k < 100) begin
      @(negedge ACLK); #1;
      k++;
      if (S_TVALID[1] && S_TREADY[1] && srcq[1].size() == 3) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midrst beat2: got no beat2 handshake want one"); end
    ARESET = 1'b1;
    @(negedge ACLK); #1;
    n_checks++;
    if (M_TVALID !== 1'b0) begin n_fail++; $display("FAIL midrst M_TVALID: got %b want 0", M_TVALID); end
    n_checks++;
    if (GRANT !== '0) begin n_fail++; $display("FAIL midrst GRANT: got %b want 0", GRANT); end
    n_checks++;
    if (S_TREADY !== '0) begin n_fail++; $display("FAIL midrst S_TREADY: got %b want 0", S_TREADY); end
    // Sources restart from scratch while reset is held.
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      mq[i].delete();
      gap_left[i] = 0;
    end
    start_scenario();
    model_last = NS - 1;
    queue_packet(1, 4, 1'b0, -1, 0);
    queue_packet(0, 2, 1'b0, -1, 0);
    model_schedule();
    @(negedge ACLK); #1;
    ARESET = 1'b0;
    wait_obs(expq.size(), 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midrst count: got %0d beats want %0d", obsq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      n_checks++;
      if (obsq[i].data !== expq[i].data || obsq[i].tid !== expq[i].tid || obsq[i].last !== expq[i].last) begin
        n_fail++;
        $display("FAIL midrst beat%0d: got data=%h tid=%0d last=%b want data=%h tid=%0d last=%b",
                 i, obsq[i].data, obsq[i].tid, obsq[i].last, expq[i].data, expq[i].tid, expq[i].last);
      end
    end
  endtask

  initial begin
    ARESET = 1'b1;
    M_TREADY = 1'b1;
    S_TVALID = '0; S_TDATA = '0; S_TSTRB = '0; S_TKEEP = '0; S_TLAST = '0; S_TDEST = '0;
    pop = '0; cyc = 0; force_valid = 1'b0; tready_toggle = 1'b0;
    for (int i = 0; i < NS; i++) begin
      gap_left[i] = 0;
      first_valid_cyc[i] = 0;
    end
    test_reset();
    test_single_source();
    test_back_to_back();
    test_valid_drop();
    test_backpressure();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
